// File: rtl/accumulate_controller.sv
// Button-driven accumulator: Sum += zext(SW) per press, computed with one SLICE-bit adder over WIDTH/SLICE cycles.
// Optional build macro ACCUM_SATURATE_EN clamps Sum to all ones on carry-out instead of wrapping.
//
//   state  | meaning
//   S_IDLE | waiting for a synchronised press (run_s 1->0)
//   S_ADD  | one slice per cycle, LSB first; commit on the last slice
//   S_DONE | result committed, waiting for the button to be released
module accumulate_controller #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4,
   parameter int SW_W  = 10
) (
   input  logic             Clk,
   input  logic             Reset_Clear,
   input  logic             Run_Accumulate,
   input  logic [SW_W-1:0]  SW,
   output logic [WIDTH-1:0] Sum,
   output logic             CO,
   output logic             Busy,
   output logic             Done
);

   localparam int N     = WIDTH / SLICE;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

   state_t             state_q;
   logic               sync1_q, sync2_q;
   logic [1:0]         fill_q;
   logic               released_q;
   logic [IDX_W-1:0]   idx_q;
   logic               carry_q;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [WIDTH-1:0]   sum_q;
   logic               co_q, busy_q, done_q;

   logic [SLICE:0]     slice_sum;
   logic [WIDTH-1:0]   shadow_d;
   logic [WIDTH-1:0]   commit_d;
   logic               is_last, press;
   int                 base;

   // released_q only trusts run_s once the synchroniser holds pin samples,
   // so a button held through reset cannot look like a fresh press.
   assign press   = released_q & ~sync2_q;
   assign is_last = (idx_q == IDX_W'(N - 1));

   always_comb begin
      base      = int'(idx_q) * SLICE;
      slice_sum = {1'b0, a_q[base +: SLICE]} + {1'b0, b_q[base +: SLICE]}
                  + {{SLICE{1'b0}}, carry_q};
      shadow_d  = a_q;
      shadow_d[base +: SLICE] = slice_sum[SLICE-1:0];
`ifdef ACCUM_SATURATE_EN
      commit_d  = slice_sum[SLICE] ? '1 : shadow_d;
`else
      commit_d  = shadow_d;
`endif
   end

   always_ff @(posedge Clk) begin
      if (Reset_Clear) begin
         state_q    <= S_IDLE;
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         fill_q     <= 2'b00;
         released_q <= 1'b0;
         idx_q      <= '0;
         carry_q    <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         sum_q      <= '0;
         co_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         sync1_q    <= Run_Accumulate;
         sync2_q    <= sync1_q;
         fill_q     <= {fill_q[0], 1'b1};
         released_q <= fill_q[1] & sync2_q;
         done_q     <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (press) begin
                  a_q     <= sum_q;
                  b_q     <= WIDTH'(SW);
                  idx_q   <= '0;
                  carry_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= S_ADD;
               end
            end
            S_ADD: begin
               a_q     <= shadow_d;
               carry_q <= slice_sum[SLICE];
               idx_q   <= idx_q + 1'b1;
               if (is_last) begin
                  sum_q   <= commit_d;
                  co_q    <= slice_sum[SLICE];
                  idx_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               if (sync2_q) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign Sum  = sum_q;
   assign CO   = co_q;
   assign Busy = busy_q;
   assign Done = done_q;

endmodule

// File: tb/tb_accumulate_controller.sv
// Directed bench for accumulate_controller: a 16/4 instance for sequencing and a 12/4 instance for overflow.
// Expected commits are queued at press time and popped when Done pulses.
module tb_accumulate_controller;

   logic        clk = 1'b0;
   logic        rst16 = 1'b1, run16 = 1'b1;
   logic [9:0]  sw16 = '0;
   logic [15:0] Sum16;
   logic        CO16, Busy16, Done16;
   logic        rst12 = 1'b1, run12 = 1'b1;
   logic [9:0]  sw12 = '0;
   logic [11:0] Sum12;
   logic        CO12, Busy12, Done12;

   int checks = 0;
   int failures = 0;

   logic [16:0] q16[$];
   logic [12:0] q12[$];
   logic [15:0] model16 = '0;
   logic [11:0] model12 = '0;
   logic [15:0] sum16_prev;
   logic        rst16_edge;

   always #5 clk = ~clk;

   accumulate_controller #(.WIDTH(16), .SLICE(4), .SW_W(10)) dut (
      .Clk(clk), .Reset_Clear(rst16), .Run_Accumulate(run16), .SW(sw16),
      .Sum(Sum16), .CO(CO16), .Busy(Busy16), .Done(Done16));

   accumulate_controller #(.WIDTH(12), .SLICE(4), .SW_W(10)) dut12 (
      .Clk(clk), .Reset_Clear(rst12), .Run_Accumulate(run12), .SW(sw12),
      .Sum(Sum12), .CO(CO12), .Busy(Busy12), .Done(Done12));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) rst16_edge <= rst16;

   // Scoreboard pops plus "Sum only moves at commit" for the 16-bit instance
   always @(negedge clk) begin
      if (Done16) begin
         if (q16.size() == 0) check("unexpected_done16", 32'd1, 32'd0);
         else begin
            logic [16:0] e;
            e = q16.pop_front();
            check("sum16", {16'd0, Sum16}, {16'd0, e[15:0]});
            check("co16", {31'd0, CO16}, {31'd0, e[16]});
         end
      end else if (rst16_edge === 1'b0) begin
         check("sum16_hold", {16'd0, Sum16}, {16'd0, sum16_prev});
      end
      sum16_prev = Sum16;
   end

   always @(negedge clk) begin
      if (Done12) begin
         if (q12.size() == 0) check("unexpected_done12", 32'd1, 32'd0);
         else begin
            logic [12:0] e;
            e = q12.pop_front();
            check("sum12", {20'd0, Sum12}, {20'd0, e[11:0]});
            check("co12", {31'd0, CO12}, {31'd0, e[12]});
         end
      end
   end

   task automatic push16(input logic [9:0] sw);
      logic [16:0] t;
      t = {1'b0, model16} + 17'(sw);
`ifdef ACCUM_SATURATE_EN
      model16 = t[16] ? 16'hFFFF : t[15:0];
`else
      model16 = t[15:0];
`endif
      q16.push_back({t[16], model16});
   endtask

   task automatic push12(input logic [9:0] sw);
      logic [12:0] t;
      t = {1'b0, model12} + 13'(sw);
`ifdef ACCUM_SATURATE_EN
      model12 = t[12] ? 12'hFFF : t[11:0];
`else
      model12 = t[11:0];
`endif
      q12.push_back({t[12], model12});
   endtask

   // mode: 0 plain, 1 SW changes during Busy, 2 button glitch during Busy, 3 reset on 2nd Busy cycle
   task automatic press16(input logic [9:0] sw, input int hold, input int mode);
      int dones = 0, lat = 0, busy = 0;
      sw16 = sw;
      run16 = 1'b0;
      if (mode != 3) push16(sw);
      for (int i = 1; i <= hold + 12; i++) begin
         @(negedge clk);
         if (Done16) begin
            dones++;
            if (lat == 0) lat = i;
         end
         if (Busy16) busy++;
         if (mode == 1 && i == 4) sw16 = 10'h3FF;
         if (mode == 2 && i == 3) run16 = 1'b1;
         if (mode == 2 && i == 4) run16 = 1'b0;
         if (mode == 3 && i == 4) rst16 = 1'b1;
         if (mode == 3 && i == 5) begin
            check("rst_mid_sum", {16'd0, Sum16}, 32'd0);
            check("rst_mid_co", {31'd0, CO16}, 32'd0);
            check("rst_mid_busy", {31'd0, Busy16}, 32'd0);
            rst16 = 1'b0;
            model16 = '0;
         end
         if (i == hold) run16 = 1'b1;
      end
      if (mode == 3) check("rst_mid_no_done", dones, 32'd0);
      else begin
         check("done_count16", dones, 32'd1);
         check("latency16", lat, 32'd7);
         check("busy_cycles16", busy, 32'd4);
      end
   endtask

   task automatic press12(input logic [9:0] sw);
      int dones = 0;
      sw12 = sw;
      run12 = 1'b0;
      push12(sw);
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         if (Done12) dones++;
         if (i == 3) run12 = 1'b1;
      end
      check("done_count12", dones, 32'd1);
   endtask

   task automatic reset16();
      rst16 = 1'b1;
      @(negedge clk);
      rst16 = 1'b0;
      model16 = '0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      check("rst_sum16", {16'd0, Sum16}, 32'd0);
      check("rst_co16", {31'd0, CO16}, 32'd0);
      check("rst_busy16", {31'd0, Busy16}, 32'd0);
      check("rst_done16", {31'd0, Done16}, 32'd0);
      check("rst_sum12", {20'd0, Sum12}, 32'd0);
      rst16 = 1'b0;
      rst12 = 1'b0;
      repeat (4) @(negedge clk);

      press16(10'h001, 3, 0);
      check("basic_first", {16'd0, Sum16}, 32'h0001);
      press16(10'h002, 3, 0);
      check("basic_second", {16'd0, Sum16}, 32'h0003);

      press16(10'h005, 40, 0);
      check("held_button", {16'd0, Sum16}, 32'h0008);

      press16(10'h00A, 3, 1);
      check("sw_stable", {16'd0, Sum16}, 32'h0012);
      press16(10'h001, 10, 2);
      check("glitch_no_second", {16'd0, Sum16}, 32'h0013);

      reset16();
      press16(10'h010, 3, 0);
      check("preset_0010", {16'd0, Sum16}, 32'h0010);
      press16(10'h0FF, 15, 3);
      check("after_rst_held", {16'd0, Sum16}, 32'h0000);
      press16(10'h003, 3, 0);
      check("after_rst_repress", {16'd0, Sum16}, 32'h0003);

      for (int k = 0; k < 4; k++) press12(10'h3FF);
      check("ovf_four_sum", {20'd0, Sum12}, 32'hFFC);
      check("ovf_four_co", {31'd0, CO12}, 32'd0);
      press12(10'h3FF);
`ifdef ACCUM_SATURATE_EN
      check("ovf_fifth_sum", {20'd0, Sum12}, 32'hFFF);
`else
      check("ovf_fifth_sum", {20'd0, Sum12}, 32'h3FB);
`endif
      check("ovf_fifth_co", {31'd0, CO12}, 32'd1);

      check("q16_drained", q16.size(), 32'd0);
      check("q12_drained", q12.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/accumulate_controller.md
# accumulate_controller

Sequenced accumulator controller for the lab adder board. It debounces nothing but synchronises the Run_Accumulate button. On each press it adds the zero-extended switch value into a WIDTH-bit running sum, using one SLICE-bit adder time-shared over WIDTH/SLICE cycles. It sits between the board buttons and switches and the LED/HEX display logic, replacing the purely combinational full-width add.

## Interface

Parameters:
- WIDTH, 16, accumulator width; must be a multiple of SLICE
- SLICE, 4, width of the shared slice adder (bits added per cycle)
- SW_W, 10, switch operand width; SW_W <= WIDTH

Ports:
- Clk  in  1  system clock; all state changes on its rising edge
- Reset_Clear  in  1  synchronous, active-high reset/clear (top level inverts the board button)
- Run_Accumulate  in  1  active-low run button, asynchronous to Clk
- SW  in  SW_W  operand; zero-extended to WIDTH
- Sum  out  WIDTH  committed accumulator value
- CO  out  1  carry out of bit WIDTH-1 from the last committed add
- Busy  out  1  high while a slice sequence is in progress
- Done  out  1  one-cycle pulse when a new Sum/CO is committed

## Operation

- Run_Accumulate passes through a 2-flop synchroniser, giving run_s, which is active-low. A press is run_s going 1->0.
- FSM states:
  - IDLE: wait for press.
  - ADD: process slices 0..N-1, LSB first, where N = WIDTH/SLICE.
  - DONE: wait for button release.
- IDLE -> ADD on press:
  - Latch B = zext(SW) and A = Sum into shadow registers.
  - Set idx = 0 and carry = 0.
- ADD, each cycle:
  - Compute {c, r} = A[idx] + B[idx] + carry, where A[idx] and B[idx] are SLICE-bit slices.
  - Write r into shadow slice idx, set carry = c, and increment idx.
- After slice N-1:
  - Commit Sum = shadow result and CO = final carry.
  - Go to DONE.
- DONE -> IDLE when run_s == 1 (button released). A held button gives exactly one accumulation.
- Presses seen in ADD or DONE are ignored and are not queued.
- Arithmetic: Sum = (Sum + zext(SW)) mod 2^WIDTH. CO = 1 iff the true sum >= 2^WIDTH.
- Sum and CO change only at commit. Between commits they hold, so displays never show partial slices.
- SW is sampled only at the IDLE->ADD edge. SW changes during ADD do not affect the result.

## Timing

- Reset (Reset_Clear high at an edge):
  - Sum = 0, CO = 0, Busy = 0, Done = 0.
  - State = IDLE; idx, carry and shadows cleared.
  - Synchroniser flops set to 1 (released).
- Reset has priority over every other event, including mid-ADD. The partial result is discarded and Sum still goes to 0.
- A button held through reset does not trigger. It must be released and pressed again.
- Press detection: Run_Accumulate low before edge E-2 causes run_s = 0 after edge E-1. The FSM enters ADD at edge E0, which is the latch edge.
- Slice k is computed on edge E(k+1). Commit happens at edge EN.
- Busy = 1 from after E0 through EN, i.e. for exactly N cycles.
- Done = 1 for exactly the one cycle after EN. It is 0 otherwise, including while DONE is held.
- Latency from button low to Sum valid: 2 sync cycles + 1 latch cycle + N cycles (WIDTH=16, SLICE=4: 7 cycles).
- Back-to-back: the next press is accepted at the earliest on the edge after the FSM returns to IDLE.
- SLICE == WIDTH is legal: N = 1, Busy is high for 1 cycle.

## Configuration

- Macro ACCUM_SATURATE_EN.
- Defined: on commit with final carry = 1, Sum = all ones (2^WIDTH-1). CO = 1 still.
- Undefined: Sum wraps modulo 2^WIDTH, and CO = 1 flags the wrap.
- Latency and handshake are identical in both builds.

## Test plan

- Basic run (WIDTH=16, SLICE=4):
  - Stimulus: Reset_Clear 1 for one cycle; SW=10'h001; Run_Accumulate low for 3 cycles, then high.
  - Response: Busy high for 4 cycles; Done pulses once; Sum=16'h0001, CO=0.
  - Then: SW=10'h002, press again. Response: Sum=16'h0003.
- Held button:
  - Stimulus: SW=10'h005, Run_Accumulate held low for 40 cycles.
  - Response: exactly one Done; Sum increases by 5 only.
- Overflow (WIDTH=12, SLICE=4), from Sum=0:
  - Stimulus: four presses with SW=10'h3FF.
  - Response: Sum=12'hFFC, CO=0.
  - Fifth press, without ACCUM_SATURATE_EN: Sum=12'h3FB, CO=1.
  - Fifth press, with ACCUM_SATURATE_EN: Sum=12'hFFF, CO=1.
- Reset mid-operation:
  - Stimulus: Sum=16'h0010; press with SW=10'h0FF; assert Reset_Clear on the 2nd Busy cycle.
  - Response: next cycle Sum=0, CO=0, Busy=0, no Done pulse. The held button causes no add until it is released and pressed again.
- Operand stability:
  - Stimulus: press with SW=10'h00A; change SW to 10'h3FF during Busy.
  - Response: Sum increases by 10.
  - Stimulus: glitch Run_Accumulate high then low during Busy.
  - Response: no second accumulation.
